// File: rtl/tdm_demux_sv.sv
// TDM receive demultiplexer: aligns on frame_start and emits whole frames.
// Optional saturating error counter port enabled by TDM_DEMUX_ERRCNT_EN.
module tdm_demux_sv #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [W-1:0]         in_data,
    input  logic                 in_valid,
    input  logic                 frame_start,
    output logic [N*W-1:0]       out_data,
    output logic                 out_valid,
    output logic [$clog2(N)-1:0] slot,
    output logic                 frame_err
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    output logic [7:0]           err_count
`endif
);

    localparam int SW = $clog2(N);
    localparam logic [SW-1:0] LAST = SW'(N - 1);
    localparam logic [SW-1:0] ONE  = SW'(1);

    typedef enum logic {
        HUNT,
        COLLECT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   slot_nxt;
    logic [N*W-1:0]  asm_q;
    logic [N*W-1:0]  asm_nxt;
    logic [N*W-1:0]  out_nxt;
    logic            ov_nxt;
    logic            err_nxt;
    logic            early;
    logic            missing;

    assign early   = frame_start && (slot != '0);
    assign missing = !frame_start && (slot == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HUNT;
            slot      <= '0;
            asm_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            slot      <= slot_nxt;
            asm_q     <= asm_nxt;
            out_data  <= out_nxt;
            out_valid <= ov_nxt;
            frame_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        asm_nxt   = asm_q;
        out_nxt   = out_data;
        ov_nxt    = 1'b0;
        err_nxt   = 1'b0;
        if (in_valid) begin
            unique case (state)
                HUNT: begin
                    if (frame_start) begin
                        asm_nxt[W-1:0] = in_data;
                        slot_nxt       = ONE;
                        state_nxt      = COLLECT;
                    end
                end
                COLLECT: begin
                    if (early) begin
                        // partial frame is thrown away; marker word restarts it
                        err_nxt        = 1'b1;
                        asm_nxt        = '0;
                        asm_nxt[W-1:0] = in_data;
                        slot_nxt       = ONE;
                    end else if (missing) begin
                        err_nxt   = 1'b1;
                        slot_nxt  = '0;
                        state_nxt = HUNT;
                    end else begin
                        asm_nxt[slot*W +: W] = in_data;
                        if (slot == LAST) begin
                            out_nxt  = {in_data, asm_q[(N-1)*W-1:0]};
                            ov_nxt   = 1'b1;
                            slot_nxt = '0;
                        end else begin
                            slot_nxt = slot + ONE;
                        end
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    slot_nxt  = '0;
                end
            endcase
        end
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= 8'd0;
        end else if (err_nxt && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: doc/tdm_demux_sv.md
# tdm_demux_sv

Time-division demultiplexer: the receive end of a mux-based TDM link, where a sender's rotating `sel` places one channel's word on a shared line per valid cycle. The block tracks frame alignment from a frame-start marker and deposits each word into its channel slot. It presents a complete N-channel frame as one registered parallel word with a one-cycle valid strobe. It sits behind the shared line, and its outputs feed per-channel consumers.

## Interface
- `N`, 4: channels per frame; legal range 2..16.
- `W`, 8: bits per channel word.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  synchronous reset, active low. Sampled on `clk`.
- `in_data`  input  W  word on the shared line.
- `in_valid`  input  1  `in_data` is a real word this cycle.
- `frame_start`  input  1  qualified by `in_valid`; marks the slot-0 word.
- `out_data`  output  N*W  last complete frame; channel k at bits [k*W +: W].
- `out_valid`  output  1  one-cycle pulse when `out_data` has just been updated.
- `slot`  output  $clog2(N)  index the next accepted word will fill.
- `frame_err`  output  1  one-cycle pulse on an alignment error.
- `err_count`  output  8  only present with TDM_DEMUX_ERRCNT_EN.

## Operation
- States:
  - HUNT: unaligned.
  - COLLECT: aligned; `slot` is valid.
- Reset (`rst_n`=0 at an edge):
  - State goes to HUNT.
  - `slot`=0, `out_data`=0, `out_valid`=0, `frame_err`=0, `err_count`=0.
  - The assembly register is cleared.
- HUNT behaviour:
  - `in_valid`&&`frame_start`: store the word in slot 0, set `slot`=1, go to COLLECT.
  - `in_valid` without `frame_start`: drop the word silently. No error pulse.
- COLLECT behaviour, when `in_valid`=1:
  - `frame_start`=1 and `slot`!=0: early marker.
    - Pulse `frame_err`.
    - Discard the partial frame.
    - Store the word as slot 0 and set `slot`=1.
  - `frame_start`=0 and `slot`==0: missing marker.
    - Pulse `frame_err`.
    - Drop the word and go to HUNT.
  - Otherwise store the word in assembly[`slot`].
  - If `slot`==N-1, the frame is complete:
    - `out_data` <= {`in_data`, assembly[N-2:0]}.
    - `out_valid` pulses.
    - `slot` wraps to 0 and the state stays COLLECT.
  - Otherwise `slot` increments.
- `in_valid`=0: no state change, no pulses. Gaps between words are unlimited.
- `out_data` holds its value until the next complete frame. A partial frame never reaches it.
- Precedence when several conditions coincide: reset > error handling > normal store.

## Timing
- All outputs are registered.
- `out_valid` and the new `out_data` appear together in the cycle after the edge that samples the slot-(N-1) word. Latency from the last word is 1 cycle.
- `frame_err` is high for exactly the cycle after the offending edge.
- Back-to-back frames at full rate (`in_valid` held high) are sustained: one `out_valid` every N cycles, with no bubble.
- Reset mid-frame: the partial frame is lost and `out_data` returns to 0. The first frame after reset needs a fresh `frame_start`.
- `frame_start` with `in_valid`=0 is ignored.

## Configuration
- `TDM_DEMUX_ERRCNT_EN` defined:
  - Adds `err_count`, an 8-bit saturating counter of `frame_err` pulses.
  - It increments on the same edge that raises `frame_err`, holds at 255, and clears only on reset.
- `TDM_DEMUX_ERRCNT_EN` undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Aligned frame (N=4, W=8):
  - Stimulus: reset, then words 0x11(fs), 0x22, 0x33, 0x44 on consecutive cycles.
  - Response: one cycle after 0x44, `out_data`=0x44332211 and `out_valid`=1 for one cycle.
- Hunt discard:
  - Stimulus: 0xAA and 0xBB without `frame_start`, then 0x01(fs), 0x02, 0x03, 0x04.
  - Response: no `frame_err`; `out_data`=0x04030201.
- Early marker:
  - Stimulus: 0x10(fs), 0x20, then 0x30(fs), 0x40, 0x50, 0x60.
  - Response: one `frame_err` pulse after 0x30; `out_data`=0x60504030.
- Missing marker:
  - Stimulus: a complete frame, then 0x77 without `frame_start`.
  - Response: `frame_err` pulses, state is HUNT, `out_data` is unchanged.
- Gaps and mid-frame reset:
  - Stimulus: a frame with `in_valid` gaps of 3 cycles is assembled correctly; then 2 words of a new frame followed by `rst_n`=0.
  - Response: all outputs are 0 and `slot`=0.
- Error counter (with `TDM_DEMUX_ERRCNT_EN`):
  - Stimulus: 300 missing-marker errors.
  - Response: `err_count`=255.
